// File: rtl/mult_seq_if.sv
// Handshake and read-back bundle between the core and the sequential multiplier.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             mult_enable;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sfmux_high;
    logic             sf2reg;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output mult_enable, a, b, sfmux_high, sf2reg,
        input  rd_data, rd_valid, busy, done, hi, lo
    );

    modport slave (
        input  mult_enable, a, b, sfmux_high, sf2reg,
        output rd_data, rd_valid, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq_unit.sv
// Iterative shift-add unsigned multiplier (MULTU) with HI/LO result registers.
// One partial-product step per cycle; busy stalls the core for WIDTH cycles.
module mult_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    mult_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             start;
    logic             last;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mplier_nxt;

    // Carry out of the add becomes the top bit of acc after the right shift.
    always_comb begin
        sum        = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : '0)};
        acc_nxt    = sum[WIDTH:1];
        mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mult_enable) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    last      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= last;
            if (start) begin
                mcand  <= bus.a;
                mplier <= bus.b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc    <= acc_nxt;
                mplier <= mplier_nxt;
                cnt    <= last ? '0 : cnt + CW'(1);
            end
            // HI and LO commit together on the final step.
            if (last) begin
                hi_r <= acc_nxt;
                lo_r <= mplier_nxt;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.rd_data  = bus.sfmux_high ? hi_r : lo_r;
    assign bus.rd_valid = bus.sf2reg & (state != RUN);
endmodule

// File: tb/tb_mult_seq_unit.sv
// Randomized and directed bench for mult_seq_unit: cycle-count reference model
// feeds a scoreboard queue; a negedge monitor checks every output.
module tb_mult_seq_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(W)) bus();

    mult_seq_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    // Reference model: a multiply occupies W cycles, then the product appears.
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] m_prod = '0;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    int             m_left = 0;
    bit             m_done = 1'b0;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_prod;
                m_done = 1'b1;
            end
        end else if (bus.mult_enable) begin
            m_left = W;
            m_prod = (2*W)'(bus.a) * (2*W)'(bus.b);
            exp_q.push_back(m_prod);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", 64'(bus.busy), 64'(m_left > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("rd_data", 64'(bus.rd_data), 64'(bus.sfmux_high ? m_hi : m_lo));
            chk("rd_valid", 64'(bus.rd_valid), 64'(bus.sf2reg && m_left == 0));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_done: got done=1 expected no pending result at %0t", $time);
                end else begin
                    chk("sb_result", {bus.hi, bus.lo}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(posedge clk);
        #1;
        bus.a = av;
        bus.b = bv;
        bus.mult_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_enable = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        if (!bus.done) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done_timeout: got no done in %0d cycles expected done", n);
        end
    endtask

    int n;
    int dcount;
    logic [W-1:0] ops[4];

    initial begin
        bus.mult_enable = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sfmux_high = 1'b0;
        bus.sf2reg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_hi", 64'(bus.hi), 64'h0);
        chk("reset_lo", 64'(bus.lo), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);

        // 1: 3*5
        start(32'd3, 32'd5);
        wait_done(n);
        chk("t1_latency", 64'(n), 64'd33);
        chk("t1_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
        chk("t1_rd_lo", 64'(bus.rd_data), 64'h0000_000F);

        // 2: max*max
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("t2_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        bus.sfmux_high = 1'b1;
        #1;
        chk("t2_rd_hi", 64'(bus.rd_data), 64'hFFFF_FFFE);
        bus.sfmux_high = 1'b0;

        // 3: enable while busy is ignored
        start(32'h0001_0000, 32'h0001_0000);
        repeat (8) @(posedge clk);
        #1;
        bus.a = 32'd7;
        bus.b = 32'd7;
        bus.mult_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_enable = 1'b0;
        wait_done(n);
        chk("t3_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) dcount++;
        end
        chk("t3_no_second_busy", 64'(dcount), 64'd0);

        // 4: read during busy returns old LO with rd_valid low
        bus.sf2reg = 1'b1;
        bus.sfmux_high = 1'b0;
        start(32'd2, 32'd9);
        @(negedge clk);
        chk("t4_rd_busy", 64'(bus.rd_data), 64'h0);
        chk("t4_valid_busy", 64'(bus.rd_valid), 64'h0);
        wait_done(n);
        chk("t4_lo", 64'(bus.lo), 64'h12);
        chk("t4_valid_done", 64'(bus.rd_valid), 64'h1);
        bus.sf2reg = 1'b0;

        // 5: reset mid-operation aborts
        start(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(bus.busy), 64'h0);
        chk("t5_hilo", {bus.hi, bus.lo}, 64'h0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("t5_no_done", 64'(dcount), 64'd0);
        start(32'd6, 32'd7);
        wait_done(n);
        chk("t5_lo", 64'(bus.lo), 64'h2A);

        // 6: back-to-back with enable held high
        @(posedge clk);
        #1;
        bus.a = 32'h0;
        bus.b = 32'hFFFF_FFFF;
        bus.mult_enable = 1'b1;
        wait_done(n);
        chk("t6_first", {bus.hi, bus.lo}, 64'h0);
        bus.a = 32'd1;
        bus.b = 32'd1;
        wait_done(n);
        bus.mult_enable = 1'b0;
        chk("t6_gap", 64'(n), 64'd33);
        chk("t6_second", {bus.hi, bus.lo}, 64'h1);

        // Random traffic: enables land in idle, busy and done cycles alike
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            ops[0] = '0;
            ops[1] = '1;
            ops[2] = $urandom;
            ops[3] = $urandom;
            bus.a = ops[$urandom_range(0, 3)];
            bus.b = ops[$urandom_range(0, 3)];
            bus.mult_enable = ($urandom_range(0, 5) == 0);
            bus.sfmux_high = $urandom_range(0, 1);
            bus.sf2reg = $urandom_range(0, 1);
        end
        bus.mult_enable = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
